cpu_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 16-bit core. It keeps the same 16-bit instruction encoding and the opcode semantics for ADD/SUB/AND/OR/LW/SW. It adds four things: a configurable datapath width, a single shared memory port with a req/ready handshake that tolerates wait states, HALT, and a retire pulse. It sits at the top of the processor and drives the system memory or bus adapter directly.

---
 rtl/cpu_mc.sv | 153 +++++++++++++++
 tb/tb_cpu_mc.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit-encoded core with a configurable datapath and a single shared
// memory port (req/ready). Supports FETCH/EXEC/MEM sequencing, HALT and a retire pulse.
module cpu_mc #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;

  logic [1:0]        state;
  logic              run;
  logic [15:0]       ir;
  logic              z;
  logic [DATA_W-1:0] regs [16];

  logic [3:0]        op;
  logic [3:0]        rs;
  logic [3:0]        rt;
  logic [3:0]        rd;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] alu_res;
  logic              is_alu;
  logic              xfer;

  assign op     = ir[15:12];
  assign rs     = ir[11:8];
  assign rt     = ir[7:4];
  assign rd     = ir[3:0];
  assign is_alu = (op <= OP_OR);
  assign pc_inc = pc + ADDR_W'(2);

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path through the block leaves a value held and no latch is inferred.
  always_comb begin
    tgt       = '0;
    tgt[12:0] = {ir[11:0], 1'b0};
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = regs[rs] + regs[rt];
      OP_SUB:  alu_res = regs[rs] - regs[rt];
      OP_AND:  alu_res = regs[rs] & regs[rt];
      OP_OR:   alu_res = regs[rs] | regs[rt];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_BEQZ: pc_next = z ? tgt : pc_inc;
      OP_JMP:  pc_next = tgt;
      default: pc_next = pc_inc;
    endcase
  end

  // run holds the bus idle for the first cycle after reset release; every bus output
  // is decoded from flops only, so reset drops the request asynchronously.
  assign mem_req   = run && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = mem_req && (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = !mem_req ? '0 : ((state == S_MEM) ? tgt : pc);
  assign mem_wdata = mem_we ? regs[2] : '0;
  assign halted    = (state == S_HALT);
  assign xfer      = mem_req && mem_ready;

  // NOTE: sequential state is updated with non-blocking '<=' so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      run    <= 1'b0;
      pc     <= RESET_PC;
      ir     <= '0;
      z      <= 1'b0;
      retire <= 1'b0;
    end else begin
      run    <= 1'b1;
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (xfer) begin
            ir    <= mem_rdata[15:0];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((op == OP_LW) || (op == OP_SW)) begin
            state <= S_MEM;
          end else if (op == OP_HALT) begin
            retire <= 1'b1;
            state  <= S_HALT;
          end else begin
            if (is_alu) z <= (alu_res == '0);
            pc     <= pc_next;
            retire <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_MEM: begin
          if (xfer) begin
            pc     <= pc_inc;
            retire <= 1'b1;
            state  <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // NOTE: the register file must read as zero after reset, so it is built from
  // resettable flops rather than a RAM macro that has no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if ((state == S_EXEC) && is_alu) begin
      regs[rd] <= alu_res;
    end else if ((state == S_MEM) && xfer && (op == OP_LW)) begin
      regs[2] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: bus responder with programmable or random wait states and an
// instruction-level reference model stepped on every retire pulse.
module tb_cpu_mc;

  localparam int             DW  = 32;
  localparam int             AW  = 16;
  localparam logic [AW-1:0]  RPC = 16'hFFFE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req, mem_we, retire, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memories and reference model ----------------
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_regs [16];
  logic          ref_z, ref_halted;
  logic [AW-1:0] ref_pc;
  int            ref_wr_reg;

  function automatic logic [DW-1:0] rd_bus(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    ref_z = 1'b0; ref_halted = 1'b0; ref_pc = RPC; ref_wr_reg = -1;
  endtask

  // Executes the instruction at ref_pc as one atomic step.
  task automatic ref_step(output logic [3:0] op_o);
    logic [DW-1:0] w, a, b, r;
    logic [15:0]   ins;
    logic [AW-1:0] t;
    w = rd_ref(ref_pc);
    ins = w[15:0];
    op_o = ins[15:12];
    a = ref_regs[ins[11:8]];
    b = ref_regs[ins[7:4]];
    t = AW'({ins[11:0], 1'b0});
    ref_wr_reg = -1;
    r = '0;
    case (op_o)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      default: r = '0;
    endcase
    if (op_o <= 4'h3) begin
      ref_regs[ins[3:0]] = r; ref_z = (r == '0); ref_wr_reg = int'(ins[3:0]);
      ref_pc = ref_pc + AW'(2);
    end else begin
      case (op_o)
        4'h4: begin ref_regs[2] = rd_ref(t); ref_wr_reg = 2; ref_pc = ref_pc + AW'(2); end
        4'h5: begin ref_mem[t] = ref_regs[2]; ref_pc = ref_pc + AW'(2); end
        4'h6: ref_pc = ref_z ? t : ref_pc + AW'(2);
        4'h7: ref_pc = t;
        4'h8: ref_halted = 1'b1;
        default: ref_pc = ref_pc + AW'(2);
      endcase
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v; ref_mem[a] = v;
  endtask

  // Instruction words carry random upper bits that the core must ignore.
  task automatic load_ins(input logic [AW-1:0] a, input logic [15:0] ins);
    logic [DW-1:0] w;
    w = $urandom();
    w[15:0] = ins;
    load(a, w);
  endtask

  task automatic clear_mem();
    mem.delete(); ref_mem.delete();
  endtask

  // ---------------- bus responder and retire monitor ----------------
  int            cyc = 0;
  int            last_ret, waits_acc, wait_cnt, wait_tgt, n_ret, n_writes, last_delta;
  int            fetch_wait = 0, data_wait = 0;
  bit            rand_waits = 1'b0;
  bit            fresh, in_req, expect_data, exp_sw;
  logic [AW-1:0] exp_tgt, cap_addr, last_wr_addr;
  logic          cap_we;
  logic [DW-1:0] cap_wdata, last_wr_data, fw;
  logic [3:0]    r_op;
  logic [AW-1:0] fetch_q [$];
  int            ret_deltas [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0; in_req = 1'b0; expect_data = 1'b0; fresh = 1'b1;
      waits_acc = 0; n_ret = 0; n_writes = 0; last_ret = 0;
      fetch_q.delete(); ret_deltas.delete();
    end else begin
      if (retire) begin
        ref_step(r_op);
        n_ret++;
        last_delta = cyc - last_ret;
        ret_deltas.push_back(last_delta);
        check("retire_cycles", last_delta, (((r_op == 4'h4) || (r_op == 4'h5)) ? 3 : 2) + waits_acc);
        last_ret = cyc; waits_acc = 0;
        check("retire_pc", pc, ref_pc);
        check("retire_halted", halted, ref_halted);
        check("retire_z", dut.z, ref_z);
        if (ref_wr_reg >= 0) check("retire_reg", dut.regs[ref_wr_reg], ref_regs[ref_wr_reg]);
      end
      if (mem_req) begin
        if (fresh) begin last_ret = cyc; fresh = 1'b0; end
        if (!in_req) begin
          in_req = 1'b1; wait_cnt = 0;
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
          wait_tgt = rand_waits ? int'($urandom_range(0, 2)) : (expect_data ? data_wait : fetch_wait);
        end else begin
          check("hold_addr", mem_addr, cap_addr);
          check("hold_we", mem_we, cap_we);
          check("hold_wdata", mem_wdata, cap_wdata);
        end
        if (wait_cnt < wait_tgt) begin
          wait_cnt++; waits_acc++;
          mem_ready = 1'b0; mem_rdata = $urandom();
        end else begin
          mem_ready = 1'b1; in_req = 1'b0;
          if (expect_data) begin
            check("data_addr", mem_addr, exp_tgt);
            check("data_we", mem_we, exp_sw);
            if (exp_sw) begin
              check("store_data", mem_wdata, ref_regs[2]);
              mem[mem_addr] = mem_wdata;
              n_writes++; last_wr_addr = mem_addr; last_wr_data = mem_wdata;
              mem_rdata = $urandom();
            end else begin
              mem_rdata = rd_bus(mem_addr);
            end
            expect_data = 1'b0;
          end else begin
            check("fetch_addr", mem_addr, ref_pc);
            check("fetch_we", mem_we, 1'b0);
            fetch_q.push_back(mem_addr);
            mem_rdata = rd_bus(mem_addr);
            fw = rd_ref(ref_pc);
            expect_data = (fw[15:12] == 4'h4) || (fw[15:12] == 4'h5);
            exp_sw = (fw[15:12] == 4'h5);
            exp_tgt = AW'({fw[11:0], 1'b0});
          end
        end
      end else begin
        in_req = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ref_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check("halt_reached", halted, 1'b1);
    @(negedge clk);
  endtask

  task automatic halt_window(input logic [AW-1:0] exp_pc);
    int reqs, r0;
    reqs = 0; r0 = n_ret;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check("halt_no_req", reqs, 0);
    check("halt_no_retire", n_ret - r0, 0);
    check("halt_pc", pc, exp_pc);
    check("halt_flag", halted, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset while an SW is stalled in MEM.
    hold_reset();
    check("rst_req_low", mem_req, 1'b0);
    check("rst_retire", retire, 1'b0);
    clear_mem();
    load_ins(RPC, 16'h9000);
    load_ins(16'h0000, 16'h5010);
    load_ins(16'h0002, 16'h8000);
    load(16'h0020, 32'h0000_1234);
    fetch_wait = 0; data_wait = 1000; rand_waits = 1'b0;
    release_reset();
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, RPC);
    for (int i = 0; i < 50 && !(mem_req && mem_we); i++) @(negedge clk);
    check("reached_mem", mem_req && mem_we, 1'b1);
    #2 rst_n = 1'b0;
    ref_reset();
    #1;
    check("abort_req", mem_req, 1'b0);
    check("abort_we", mem_we, 1'b0);
    check("abort_addr", mem_addr, 16'h0000);
    check("abort_wdata", mem_wdata, 32'h0);
    check("abort_halted", halted, 1'b0);
    check("abort_pc", pc, RPC);
    check("abort_no_write", rd_bus(16'h0020), 32'h0000_1234);
    repeat (2) @(negedge clk);
    data_wait = 0;
    release_reset();
    for (int i = 0; i < 16; i++) check("post_rst_reg", dut.regs[i], 32'h0);
    check("post_rst_z", dut.z, 1'b0);
    check("post_rst_pc", pc, RPC);
    run_until_halt(100);
    check("wrap_fetch0", fetch_q[0], RPC);
    check("wrap_fetch1", fetch_q[1], 16'h0000);
    check("sw_zero", rd_bus(16'h0020), 32'h0);

    // LW then ADD, zero wait states.
    hold_reset();
    clear_mem();
    load_ins(RPC, 16'h9000);
    load_ins(16'h0000, 16'h4010);
    load_ins(16'h0002, 16'h0223);
    load_ins(16'h0004, 16'h8000);
    load(16'h0020, 32'd5);
    release_reset();
    run_until_halt(100);
    check("lw_r2", dut.regs[2], 32'd5);
    check("add_r3", dut.regs[3], 32'd10);
    check("lw_cycles", ret_deltas[1], 3);
    check("add_cycles", ret_deltas[2], 2);
    check("halt_retire_count", ret_deltas.size(), 4);
    halt_window(16'h0004);

    // SUB sets Z, BEQZ taken.
    hold_reset();
    clear_mem();
    load_ins(RPC, 16'h9000);
    load_ins(16'h0000, 16'h1224);
    load_ins(16'h0002, 16'h6040);
    load_ins(16'h0004, 16'h8000);
    load_ins(16'h0080, 16'h8000);
    release_reset();
    run_until_halt(100);
    check("beqz_taken_fetch", fetch_q[3], 16'h0080);
    check("beqz_taken_pc", pc, 16'h0080);
    check("sub_z", dut.z, 1'b1);

    // ADD clears Z, BEQZ falls through.
    hold_reset();
    clear_mem();
    load_ins(RPC, 16'h9000);
    load_ins(16'h0000, 16'h4010);
    load_ins(16'h0002, 16'h0224);
    load_ins(16'h0004, 16'h6040);
    load_ins(16'h0006, 16'h8000);
    load_ins(16'h0080, 16'h8000);
    load(16'h0020, 32'd7);
    release_reset();
    run_until_halt(100);
    check("beqz_not_taken_fetch", fetch_q[4], 16'h0006);
    check("add_r4", dut.regs[4], 32'd14);

    // SW with three wait states on both FETCH and MEM.
    hold_reset();
    clear_mem();
    load_ins(RPC, 16'h9000);
    load_ins(16'h0000, 16'h4018);
    load_ins(16'h0002, 16'h5010);
    load_ins(16'h0004, 16'h8000);
    load(16'h0030, 32'h0000_BEEF);
    fetch_wait = 3; data_wait = 3;
    release_reset();
    run_until_halt(200);
    check("sw_write_count", n_writes, 1);
    check("sw_write_addr", last_wr_addr, 16'h0020);
    check("sw_write_data", last_wr_data, 32'h0000_BEEF);
    check("sw_cycles", ret_deltas[2], 9);

    // 32-bit wrap: 0xFFFFFFFF + 1 = 0 with Z set.
    hold_reset();
    clear_mem();
    load_ins(RPC, 16'h9000);
    load_ins(16'h0000, 16'h4010);
    load_ins(16'h0002, 16'h0203);
    load_ins(16'h0004, 16'h4011);
    load_ins(16'h0006, 16'h0324);
    load_ins(16'h0008, 16'h8000);
    load(16'h0020, 32'hFFFF_FFFF);
    load(16'h0022, 32'h0000_0001);
    fetch_wait = 0; data_wait = 0;
    release_reset();
    run_until_halt(100);
    check("wrap_r3", dut.regs[3], 32'hFFFF_FFFF);
    check("wrap_r4", dut.regs[4], 32'h0);
    check("wrap_z", dut.z, 1'b1);

    // Random programs with random wait states and self-modifying stores.
    rand_waits = 1'b1;
    for (int t = 0; t < 3; t++) begin
      hold_reset();
      clear_mem();
      load_ins(RPC, 16'h9000);
      for (int a = 0; a < 256; a += 2) begin
        logic [3:0]  rop;
        logic [11:0] rlo;
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'h8) rop = 4'h9;
        rlo = 12'($urandom());
        if ((rop >= 4'h4) && (rop <= 4'h7)) rlo = 12'($urandom_range(0, 127));
        load_ins(AW'(a), {rop, rlo});
      end
      release_reset();
      for (int i = 0; i < 3000 && n_ret < 150; i++) @(negedge clk);
      check("rand_progress", n_ret >= 150, 1'b1);
    end

    hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
